// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RISC-V core: load-use and branch
// stall/flush generation, EX operand forwarding, and a data-memory wait FSM.
module hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        ABORT = 2'b10
    } state_t;

    state_t              r_state;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic                r_mem_timeout;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic                w_mem_stall;
    logic                w_lw_stall;
    logic                w_stall_f;

    // Reset gates the memory stall so it drops without waiting for a clock edge.
    assign w_mem_stall = dmem_req & ~dmem_ready & (r_state != ABORT) & ~reset;
    assign w_lw_stall  = (ResultSrcE == 2'b01) & (RdE != 5'd0) &
                         ((Rs1D == RdE) | (Rs2D == RdE));
    assign w_stall_f   = w_mem_stall | w_lw_stall;

    assign StallF       = w_stall_f;
    assign StallD       = w_stall_f;
    assign StallE       = w_mem_stall;
    assign StallM       = w_mem_stall;
    assign FlushW       = w_mem_stall;
    assign FlushD       = PCSrcE & ~w_mem_stall;
    assign FlushE       = (w_lw_stall | PCSrcE) & ~w_mem_stall;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;

    // Forwarding select: a MEM-stage producer is younger than WB, so it wins.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end else begin
            ForwardAE = 2'b00;
        end
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end else begin
            ForwardBE = 2'b00;
        end
    end

    // Memory-wait FSM with watchdog; ABORT releases the pipeline for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_stall) begin
                        r_state    <= WAIT;
                        r_wait_cnt <= WCNT_W'(1);
                    end else begin
                        r_state    <= IDLE;
                    end
                end
                WAIT: begin
                    if (dmem_ready || !dmem_req) begin
                        r_state    <= IDLE;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        r_state       <= ABORT;
                        r_wait_cnt    <= '0;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    end
                end
                ABORT: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= '0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the front end is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall_f && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (TIMEOUT=4, CNT_W=4): expectations are queued
// as each input vector is applied and compared once the outputs have settled.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, dmem_req, dmem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_timeout;
    logic [3:0] stall_cycles;

    typedef struct packed {
        logic [3:0] stl;   // F, D, E, M
        logic [2:0] fl;    // D, E, W
        logic [1:0] fa;
        logic [1:0] fb;
        logic       to;
        logic [3:0] sc;
    } vec_t;

    vec_t       sb[$];
    vec_t       got, exp_v;
    int         n_vec = 0;
    int         n_err = 0;
    logic       exp_to = 1'b0;
    logic [3:0] exp_sc = 4'd0;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic vec_t observe();
        vec_t v;
        v.stl = {StallF, StallD, StallE, StallM};
        v.fl  = {FlushD, FlushE, FlushW};
        v.fa  = ForwardAE;
        v.fb  = ForwardBE;
        v.to  = mem_timeout;
        v.sc  = stall_cycles;
        return v;
    endfunction

    // Queue the expected outputs for the vector just applied; the counter model
    // then advances for the clock edge that follows if the front end is held.
    task automatic push_exp(input logic [3:0] stl, input logic [2:0] fl,
                            input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.stl = stl; v.fl = fl; v.fa = fa; v.fb = fb; v.to = exp_to; v.sc = exp_sc;
        sb.push_back(v);
        if (stl[3] && exp_sc != 4'hF) exp_sc = exp_sc + 4'd1;
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        exp_sc = 4'd0; exp_to = 1'b0;
        next_cycle();
        push_exp(4'b0000, 3'b000, 2'b00, 2'b00);
        #2;
        got = observe(); exp_v = sb.pop_front(); n_vec++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL reset: got %h expected %h", got, exp_v);
        end
        next_cycle();
        reset = 1'b0;
        push_exp(4'b0000, 3'b000, 2'b00, 2'b00);
        #2;
        got = observe(); exp_v = sb.pop_front(); n_vec++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL reset_release: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_forwarding();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            clear_inputs();
            case (i)
                0: begin RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
                         Rs1E = 5'd5; Rs2E = 5'd0; push_exp(4'b0, 3'b0, 2'b10, 2'b00); end
                1: begin RegWriteW = 1'b1; RdM = 5'd5; RdW = 5'd5;
                         Rs1E = 5'd5; push_exp(4'b0, 3'b0, 2'b01, 2'b00); end
                2: begin RegWriteW = 1'b1; RdM = 5'd5; RdW = 5'd0;
                         Rs1E = 5'd0; push_exp(4'b0, 3'b0, 2'b00, 2'b00); end
                3: begin RegWriteM = 1'b1; RdM = 5'd9; RegWriteW = 1'b1; RdW = 5'd9;
                         Rs1E = 5'd3; Rs2E = 5'd9; push_exp(4'b0, 3'b0, 2'b00, 2'b10); end
                4: begin RegWriteM = 1'b1; RegWriteW = 1'b1;
                         push_exp(4'b0, 3'b0, 2'b00, 2'b00); end
                default: begin RegWriteW = 1'b1; RdW = 5'd12; RdM = 5'd12;
                         Rs1E = 5'd12; Rs2E = 5'd12; push_exp(4'b0, 3'b0, 2'b01, 2'b01); end
            endcase
            #2;
            got = observe(); exp_v = sb.pop_front(); n_vec++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL forward step %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            clear_inputs();
            ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
            if (i < 2) begin
                push_exp(4'b1100, 3'b010, 2'b00, 2'b00);
            end else if (i == 2) begin
                RdE = 5'd0; Rs2D = 5'd0;
                push_exp(4'b0000, 3'b000, 2'b00, 2'b00);
            end else if (i == 3) begin
                ResultSrcE = 2'b00;
                push_exp(4'b0000, 3'b000, 2'b00, 2'b00);
            end else begin
                Rs2D = 5'd1; Rs1D = 5'd7;
                push_exp(4'b1100, 3'b010, 2'b00, 2'b00);
            end
            #2;
            got = observe(); exp_v = sb.pop_front(); n_vec++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL load_use step %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            clear_inputs();
            PCSrcE = 1'b1;
            if (i == 0) begin
                push_exp(4'b0000, 3'b110, 2'b00, 2'b00);
            end else begin
                ResultSrcE = 2'b01; RdE = 5'd4; Rs1D = 5'd4;
                push_exp(4'b1100, 3'b110, 2'b00, 2'b00);
            end
            #2;
            got = observe(); exp_v = sb.pop_front(); n_vec++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL branch step %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            clear_inputs();
            PCSrcE = 1'b1; dmem_req = 1'b1;
            if (i < 3) begin
                push_exp(4'b1111, 3'b001, 2'b00, 2'b00);
            end else if (i == 3) begin
                dmem_ready = 1'b1;
                push_exp(4'b0000, 3'b110, 2'b00, 2'b00);
            end else begin
                PCSrcE = 1'b0; dmem_req = 1'b0;
                push_exp(4'b0000, 3'b000, 2'b00, 2'b00);
            end
            #2;
            got = observe(); exp_v = sb.pop_front(); n_vec++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL mem_wait step %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            clear_inputs();
            dmem_req = (i < 6);
            if (i == 4) begin
                exp_to = 1'b1;
                push_exp(4'b0000, 3'b000, 2'b00, 2'b00);
            end else if (i < 6) begin
                push_exp(4'b1111, 3'b001, 2'b00, 2'b00);
            end else begin
                push_exp(4'b0000, 3'b000, 2'b00, 2'b00);
            end
            #2;
            got = observe(); exp_v = sb.pop_front(); n_vec++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL timeout cycle %0d: got %h expected %h", i + 1, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            clear_inputs();
            dmem_req = 1'b1;
            push_exp(4'b1111, 3'b001, 2'b00, 2'b00);
            #2;
            got = observe(); exp_v = sb.pop_front(); n_vec++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL mid_wait step %0d: got %h expected %h", i, got, exp_v);
            end
        end
        // Reset lands between clock edges with the access still pending.
        #1;
        reset = 1'b1;
        exp_to = 1'b0; exp_sc = 4'd0;
        push_exp(4'b0000, 3'b000, 2'b00, 2'b00);
        #1;
        got = observe(); exp_v = sb.pop_front(); n_vec++;
        if (got !== exp_v) begin
            n_err++; $display("FAIL async_reset: got %h expected %h", got, exp_v);
        end
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            if (i > 0) next_cycle();
            push_exp(4'b0000, 3'b000, 2'b00, 2'b00);
            #2;
            got = observe(); exp_v = sb.pop_front(); n_vec++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL post_reset step %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 22; i++) begin
            next_cycle();
            clear_inputs();
            ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
            push_exp(4'b1100, 3'b010, 2'b00, 2'b00);
            #2;
            got = observe(); exp_v = sb.pop_front(); n_vec++;
            if (got !== exp_v) begin
                n_err++; $display("FAIL saturate cycle %0d: got %h expected %h", i, got, exp_v);
            end
        end
        next_cycle();
        clear_inputs();
        push_exp(4'b0000, 3'b000, 2'b00, 2'b00);
        #2;
        got = observe(); exp_v = sb.pop_front(); n_vec++;
        if (got !== exp_v || stall_cycles !== 4'hF) begin
            n_err++; $display("FAIL saturate_hold: got %h expected %h", got, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
